// File: rtl/lzd_norm_control.sv
// -----------------------------------------------------------------------------
// lzd_norm_control
//
// Two-stage leading-zero detector and normalization control. It sits in front
// of the normalization barrel shifter and turns the add/sub significand result
// (plus its carry-out) into the shift amount, direction and shift-in bit for
// that shifter.
//
// Stage 1 splits the significand into SEG-bit segments from the MSB and
// registers a per-segment all-zero flag and local leading-zero count.
// Stage 2 picks the first non-zero segment and forms the full count.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset
//   load_i         input valid; Data_i / carry_i sampled when high
//   Data_i         [SWR-1:0] significand result, MSB = bit SWR-1
//   carry_i        add carry-out (significand overflow)
//   valid_o        one-cycle pulse: outputs carry a new result
//   Shift_Value_o  [EWR-1:0] normalization shift amount
//   Left_Right_o   1 = left shift, 0 = right shift
//   Bit_Shift_o    bit shifted in at the vacated end
//   zero_o         significand is zero
//
// Handshake: load_i is a valid-only strobe (no ready, no backpressure). Each
// cycle load_i is high produces exactly one valid_o pulse two clock edges
// later, in order. Between pulses the result outputs hold their last value.
// -----------------------------------------------------------------------------
module lzd_norm_control #(
    parameter int SWR = 55,
    parameter int EWR = 6,
    parameter int SEG = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [SWR-1:0] Data_i,
    input  logic           carry_i,
    output logic           valid_o,
    output logic [EWR-1:0] Shift_Value_o,
    output logic           Left_Right_o,
    output logic           Bit_Shift_o,
    output logic           zero_o
);

    localparam int K  = (SWR + SEG - 1) / SEG;        // number of segments
    localparam int PW = K * SEG;                      // padded width
    localparam int LW = (SEG > 1) ? $clog2(SEG) : 1;  // local count width

    // Leading-zero count within one segment. Scanning up from the LSB lets
    // the highest set bit win. The all-zero case is flagged separately.
    function automatic logic [LW-1:0] seg_lzc(input logic [SEG-1:0] s);
        logic [LW-1:0] c;
        c = '0;
        for (int b = 0; b < SEG; b++) begin
            if (s[b]) c = LW'(SEG - 1 - b);
        end
        return c;
    endfunction

    // ---------------- Stage 1: per-segment encoding ----------------
    logic [PW-1:0]         padded;
    logic [K-1:0]          seg_zero_d;
    logic [K-1:0][LW-1:0]  seg_cnt_d;

    // The partial last segment is filled with ones on the LSB side so the
    // count never runs past the real data. Those ones can make a zero input
    // look non-zero here; the separate full-zero flag resolves that case.
    always_comb begin
        padded              = '1;
        padded[PW-1 -: SWR] = Data_i;
        seg_zero_d          = '0;
        seg_cnt_d           = '0;
        for (int k = 0; k < K; k++) begin
            seg_zero_d[k] = ~|padded[PW-1-k*SEG -: SEG];
            seg_cnt_d[k]  = seg_lzc(padded[PW-1-k*SEG -: SEG]);
        end
    end

    logic [K-1:0]          seg_zero_q;
    logic [K-1:0][LW-1:0]  seg_cnt_q;
    logic                  carry1_q;
    logic                  zero1_q;
    logic                  v1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_zero_q <= '0;
            seg_cnt_q  <= '0;
            carry1_q   <= 1'b0;
            zero1_q    <= 1'b0;
            v1_q       <= 1'b0;
        end else begin
            v1_q <= load_i;
            if (load_i) begin
                seg_zero_q <= seg_zero_d;
                seg_cnt_q  <= seg_cnt_d;
                carry1_q   <= carry_i;
                zero1_q    <= (Data_i == '0);
            end
        end
    end

    // ---------------- Stage 2: segment select and output rules ----------------
    logic [EWR-1:0] lz_d;

    // Walk from the LSB segment upward so the first non-zero segment from the
    // MSB is the last assignment.
    always_comb begin
        lz_d = '0;
        for (int k = K - 1; k >= 0; k--) begin
            if (!seg_zero_q[k]) lz_d = EWR'(k * SEG) + EWR'(seg_cnt_q[k]);
        end
    end

    logic           v2_q;
    logic [EWR-1:0] shift_q;
    logic           lr_q;
    logic           bs_q;
    logic           zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            shift_q <= '0;
            lr_q    <= 1'b0;
            bs_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                if (carry1_q) begin
                    // Overflow: shift right by one, carry re-enters at the MSB.
                    shift_q <= EWR'(1);
                    lr_q    <= 1'b0;
                    bs_q    <= 1'b1;
                    zero_q  <= 1'b0;
                end else if (zero1_q) begin
                    shift_q <= '0;
                    lr_q    <= 1'b1;
                    bs_q    <= 1'b0;
                    zero_q  <= 1'b1;
                end else begin
                    shift_q <= lz_d;
                    lr_q    <= 1'b1;
                    bs_q    <= 1'b0;
                    zero_q  <= 1'b0;
                end
            end
        end
    end

    assign valid_o       = v2_q;
    assign Shift_Value_o = shift_q;
    assign Left_Right_o  = lr_q;
    assign Bit_Shift_o   = bs_q;
    assign zero_o        = zero_q;

endmodule

// File: tb/tb_lzd_norm_control.sv
// -----------------------------------------------------------------------------
// Testbench for lzd_norm_control (SWR=55, EWR=6, SEG=8).
// Inputs are driven and outputs sampled on the falling clock edge. Result
// words are packed as {Shift_Value_o, Left_Right_o, Bit_Shift_o, zero_o}.
// -----------------------------------------------------------------------------
module tb_lzd_norm_control;

    localparam int SWR = 55;
    localparam int EWR = 6;
    localparam int SEG = 8;
    localparam int W   = EWR + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           load_i  = 1'b0;
    logic [SWR-1:0] data_i  = '0;
    logic           carry_i = 1'b0;
    logic           valid_o;
    logic [EWR-1:0] shift_o;
    logic           lr_o;
    logic           bs_o;
    logic           zero_o;

    lzd_norm_control #(.SWR(SWR), .EWR(EWR), .SEG(SEG)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load_i),
        .Data_i        (data_i),
        .carry_i       (carry_i),
        .valid_o       (valid_o),
        .Shift_Value_o (shift_o),
        .Left_Right_o  (lr_o),
        .Bit_Shift_o   (bs_o),
        .zero_o        (zero_o)
    );

    logic [W-1:0] obs;
    assign obs = {shift_o, lr_o, bs_o, zero_o};

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: straight scan of the whole significand, then the output rules.
    function automatic logic [W-1:0] ref_out(input logic [SWR-1:0] d, input logic c);
        logic [EWR-1:0] lz;
        lz = '0;
        for (int b = 0; b < SWR; b++) begin
            if (d[b]) lz = EWR'(SWR - 1 - b);
        end
        if (c)            return {EWR'(1), 1'b0, 1'b1, 1'b0};
        else if (d == '0) return {EWR'(0), 1'b1, 1'b0, 1'b1};
        else              return {lz,      1'b1, 1'b0, 1'b0};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                check("sb_result", obs, exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    // One load, then exact latency, result and hold checks.
    task automatic run_one(input string tag, input logic [SWR-1:0] d, input logic c,
                           input logic [W-1:0] exp);
        @(negedge clk);
        load_i  = 1'b1;
        data_i  = d;
        carry_i = c;
        exp_q.push_back(exp);
        @(negedge clk);
        load_i  = 1'b0;
        data_i  = '1;          // junk that must not be picked up
        carry_i = 1'b0;
        check({tag, "_lat1_valid"}, valid_o, 0);
        @(negedge clk);
        check({tag, "_lat2_valid"}, valid_o, 1);
        check({tag, "_result"}, obs, exp);
        @(negedge clk);
        check({tag, "_hold_valid"}, valid_o, 0);
        check({tag, "_hold"}, obs, exp);
    endtask

    // Back-to-back random loads; valid_o must form one unbroken run.
    task automatic run_stream(input int n);
        logic [63:0]    r;
        logic [SWR-1:0] d;
        logic           c;
        for (int m = 0; m < n + 3; m++) begin
            @(negedge clk);
            check("stream_valid", valid_o, ((m >= 2) && (m <= n + 1)) ? 1 : 0);
            if (m < n) begin
                r = {$urandom, $urandom};
                if (m % 3 == 0) d = SWR'($urandom_range(1, 127));   // partial segment only
                else            d = r[SWR-1:0] >> $urandom_range(0, SWR - 1);
                c = (m % 7 == 3);
                load_i  = 1'b1;
                data_i  = d;
                carry_i = c;
                exp_q.push_back(ref_out(d, c));
            end else begin
                load_i  = 1'b0;
                carry_i = 1'b0;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        check("reset_valid", valid_o, 0);
        check("reset_outputs", obs, 0);
        rst = 1'b0;
        @(negedge clk);

        run_one("normalized", 55'h1 << 54, 1'b0, {6'd0, 1'b1, 1'b0, 1'b0});
        run_one("max_left",   55'h1,       1'b0, {6'd54, 1'b1, 1'b0, 1'b0});
        run_one("seg_edge47", 55'h1 << 47, 1'b0, {6'd7, 1'b1, 1'b0, 1'b0});
        run_one("seg_edge46", 55'h1 << 46, 1'b0, {6'd8, 1'b1, 1'b0, 1'b0});
        run_one("bit6",       55'h40,      1'b0, {6'd48, 1'b1, 1'b0, 1'b0});
        run_one("carry_zero", 55'h0,       1'b1, {6'd1, 1'b0, 1'b1, 1'b0});
        run_one("carry_b10",  55'h1 << 10, 1'b1, {6'd1, 1'b0, 1'b1, 1'b0});
        run_one("zero",       55'h0,       1'b0, {6'd0, 1'b1, 1'b0, 1'b1});

        run_stream(20);
        check("stream_drained", exp_q.size(), 0);

        // Give the outputs a non-zero value so the reset clear is visible.
        run_one("pre_reset",  55'h0,       1'b1, {6'd1, 1'b0, 1'b1, 1'b0});

        // Reset while a load is in flight: it must vanish.
        @(negedge clk);
        load_i = 1'b1;
        data_i = 55'h1 << 30;
        @(negedge clk);
        load_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", obs, 0);
        check("async_rst_valid", valid_o, 0);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_valid_a", valid_o, 0);
        @(negedge clk);
        check("post_rst_valid_b", valid_o, 0);
        check("post_rst_outputs", obs, 0);

        run_one("after_reset", 55'h1 << 46, 1'b0, {6'd8, 1'b1, 1'b0, 1'b0});
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
